// File: rtl/ifetch_mem_bridge.sv
// Instruction fetch bridge: range-checked word fetches served from a single-port
// synchronous SRAM, with a fixed-latency tracking pipeline and an in-order response FIFO.
module ifetch_mem_bridge #(
  parameter int unsigned             C_BUS_SZX     = 5,
  parameter int unsigned             C_BUS_SZ      = 2**C_BUS_SZX,
  parameter int unsigned             C_MEM_LAT     = 1,
  parameter int unsigned             C_RSP_DEPTH_X = 2,
  parameter logic [C_BUS_SZ-1:0]     C_ADDR_BASE   = '0,
  parameter int unsigned             C_ADDR_SIZE_X = 12
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       clk_en_i,
  output logic                       ireqready_o,
  input  logic                       ireqvalid_i,
  input  logic [1:0]                 ireqhpl_i,
  input  logic [C_BUS_SZ-1:0]        ireqaddr_i,
  input  logic                       irspready_i,
  output logic                       irspvalid_o,
  output logic                       irsprerr_o,
  output logic [C_BUS_SZ-1:0]        irspdata_o,
  output logic                       mem_ce_o,
  output logic                       mem_en_o,
  output logic [C_ADDR_SIZE_X-3:0]   mem_addr_o,
  input  logic [C_BUS_SZ-1:0]        mem_rdata_i
);

  localparam int unsigned DEPTH = 2**C_RSP_DEPTH_X;
  localparam logic [C_RSP_DEPTH_X:0] FULL_LVL = {1'b1, {C_RSP_DEPTH_X{1'b0}}};
  localparam logic [C_RSP_DEPTH_X:0] ONE      = {{C_RSP_DEPTH_X{1'b0}}, 1'b1};

  logic [C_RSP_DEPTH_X:0]   level_q;
  logic [C_RSP_DEPTH_X:0]   wr_ptr, rd_ptr;
  logic [C_RSP_DEPTH_X-1:0] wr_idx, rd_idx;
  logic [C_MEM_LAT-1:0]     pipe_vld, pipe_err;
  logic [C_BUS_SZ-1:0]      data_mem [DEPTH];
  logic [DEPTH-1:0]         err_mem;

  logic accept, err, misaligned, out_of_range, bad_hpl;
  logic push, pop, empty, full;

  // Base is window-aligned, so range check reduces to matching the bits above the window.
  assign misaligned   = |ireqaddr_i[1:0];
  assign out_of_range = (ireqaddr_i >> C_ADDR_SIZE_X) != (C_ADDR_BASE >> C_ADDR_SIZE_X);
  assign bad_hpl      = (ireqhpl_i == 2'b10);
  assign err          = misaligned | out_of_range | bad_hpl;

  assign ireqready_o = clk_en_i & ~reset_i & (level_q != FULL_LVL);
  assign accept      = clk_en_i & ireqvalid_i & ireqready_o;

  assign mem_ce_o   = clk_en_i;
  assign mem_en_o   = accept & ~err;
  assign mem_addr_o = reset_i ? '0 : ireqaddr_i[C_ADDR_SIZE_X-1:2];

  assign wr_idx      = wr_ptr[C_RSP_DEPTH_X-1:0];
  assign rd_idx      = rd_ptr[C_RSP_DEPTH_X-1:0];
  assign empty       = (wr_ptr == rd_ptr);
  assign full        = ((wr_ptr ^ rd_ptr) == FULL_LVL);
  assign push        = clk_en_i & pipe_vld[C_MEM_LAT-1];
  assign pop         = clk_en_i & ~empty & irspready_i;

  assign irspvalid_o = ~empty;
  assign irsprerr_o  = ~empty & err_mem[rd_idx];
  assign irspdata_o  = data_mem[rd_idx];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      level_q  <= '0;
      pipe_vld <= '0;
      pipe_err <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else if (clk_en_i) begin
      if (accept && !pop)
        level_q <= level_q + ONE;
      else if (!accept && pop)
        level_q <= level_q - ONE;
      pipe_vld[0] <= accept;
      pipe_err[0] <= err;
      for (int unsigned i = 1; i < C_MEM_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_err[i] <= pipe_err[i-1];
      end
      if (push)
        wr_ptr <= wr_ptr + ONE;
      if (pop)
        rd_ptr <= rd_ptr + ONE;
    end
  end

  // Storage needs no reset: pointers alone decide what is visible.
  always_ff @(posedge clk_i) begin
    if (push) begin
      data_mem[wr_idx] <= pipe_err[C_MEM_LAT-1] ? '0 : mem_rdata_i;
      err_mem[wr_idx]  <= pipe_err[C_MEM_LAT-1];
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i) push |-> !full);

endmodule

// File: tb/tb_ifetch_mem_bridge.sv
// Directed self-checking bench for ifetch_mem_bridge with a one-cycle SRAM model;
// word w of the SRAM holds 0xC0DE0000|w except word 4, which holds 0xDEADBEEF.
module tb_ifetch_mem_bridge;

  logic        clk = 1'b0;
  logic        reset_i, clk_en_i, ireqvalid_i, irspready_i;
  logic [1:0]  ireqhpl_i;
  logic [31:0] ireqaddr_i;
  logic        ireqready_o, irspvalid_o, irsprerr_o, mem_ce_o, mem_en_o;
  logic [31:0] irspdata_o, mem_rdata_i;
  logic [9:0]  mem_addr_o;

  logic [31:0] sram [1024];
  logic [32:0] got_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_ce_o && mem_en_o) mem_rdata_i <= sram[mem_addr_o];

  ifetch_mem_bridge #(.C_MEM_LAT(1), .C_RSP_DEPTH_X(2), .C_ADDR_SIZE_X(12)) dut (
    .clk_i(clk), .reset_i(reset_i), .clk_en_i(clk_en_i),
    .ireqready_o(ireqready_o), .ireqvalid_i(ireqvalid_i), .ireqhpl_i(ireqhpl_i),
    .ireqaddr_i(ireqaddr_i), .irspready_i(irspready_i), .irspvalid_o(irspvalid_o),
    .irsprerr_o(irsprerr_o), .irspdata_o(irspdata_o), .mem_ce_o(mem_ce_o),
    .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i)
  );

  // Collects up to n responses with irspready held high; starts and ends just after a posedge.
  task automatic drain(input int n, input int budget);
    irspready_i = 1'b1;
    got_q.delete();
    for (int c = 0; c < budget && got_q.size() < n; c++) begin
      @(negedge clk);
      if (irspvalid_o) got_q.push_back({irsprerr_o, irspdata_o});
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1; clk_en_i = 1'b1; ireqvalid_i = 1'b1; ireqhpl_i = 2'b00;
    ireqaddr_i = 32'h10; irspready_i = 1'b0;
    @(negedge clk);
    n_checks++; if (ireqready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b exp 0", ireqready_o); end
    n_checks++; if (irspvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rspvalid got %b exp 0", irspvalid_o); end
    n_checks++; if (irsprerr_o !== 1'b0) begin n_fail++; $display("FAIL reset_rerr got %b exp 0", irsprerr_o); end
    n_checks++; if (mem_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en got %b exp 0", mem_en_o); end
    n_checks++; if (mem_addr_o !== 10'd0) begin n_fail++; $display("FAIL reset_mem_addr got %0d exp 0", mem_addr_o); end
    @(posedge clk); #1;
    reset_i = 1'b0; ireqvalid_i = 1'b0;
    @(negedge clk);
    n_checks++; if (ireqready_o !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready got %b exp 1", ireqready_o); end
    n_checks++; if (dut.level_q !== 3'd0) begin n_fail++; $display("FAIL post_reset_level got %0d exp 0", dut.level_q); end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    irspready_i = 1'b1; ireqvalid_i = 1'b1; ireqaddr_i = 32'h10; ireqhpl_i = 2'b00;
    @(negedge clk);
    n_checks++; if (mem_en_o !== 1'b1) begin n_fail++; $display("FAIL single_mem_en got %b exp 1", mem_en_o); end
    n_checks++; if (mem_addr_o !== 10'd4) begin n_fail++; $display("FAIL single_mem_addr got %0d exp 4", mem_addr_o); end
    @(posedge clk); #1;
    ireqvalid_i = 1'b0;
    @(negedge clk);
    n_checks++; if (irspvalid_o !== 1'b0) begin n_fail++; $display("FAIL single_early_valid got %b exp 0", irspvalid_o); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (irspvalid_o !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b exp 1", irspvalid_o); end
    n_checks++; if (irsprerr_o !== 1'b0) begin n_fail++; $display("FAIL single_rerr got %b exp 0", irsprerr_o); end
    n_checks++; if (irspdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_data got %h exp deadbeef", irspdata_o); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (irspvalid_o !== 1'b0) begin n_fail++; $display("FAIL single_popped got %b exp 0", irspvalid_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_errors();
    logic [31:0] addr [4];
    logic [1:0]  hpl  [4];
    logic        men  [4];
    logic [32:0] exp_r [4];
    addr = '{32'h1000, 32'h8, 32'h2, 32'h14};
    hpl  = '{2'b00, 2'b00, 2'b00, 2'b10};
    men  = '{1'b0, 1'b1, 1'b0, 1'b0};
    exp_r = '{{1'b1, 32'h0}, {1'b0, 32'hC0DE0002}, {1'b1, 32'h0}, {1'b1, 32'h0}};
    irspready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ireqvalid_i = 1'b1; ireqaddr_i = addr[i]; ireqhpl_i = hpl[i];
      @(negedge clk);
      n_checks++; if (mem_en_o !== men[i]) begin n_fail++; $display("FAIL err_mem_en[%0d] got %b exp %b", i, mem_en_o, men[i]); end
      n_checks++; if (ireqready_o !== 1'b1) begin n_fail++; $display("FAIL err_ready[%0d] got %b exp 1", i, ireqready_o); end
      @(posedge clk); #1;
    end
    ireqvalid_i = 1'b0; ireqhpl_i = 2'b00;
    drain(4, 20);
    n_checks++; if (got_q.size() != 4) begin n_fail++; $display("FAIL err_count got %0d exp 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_r[i]) begin n_fail++; $display("FAIL err_rsp[%0d] got %h exp %h", i, got_q[i], exp_r[i]); end
    end
  endtask

  task automatic test_backpressure();
    int          issued = 0;
    logic [31:0] d0, d1;
    irspready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ireqvalid_i = 1'b1; ireqaddr_i = 32'h20 + 32'(4 * issued);
      @(negedge clk);
      n_checks++; if (ireqready_o !== (i < 4)) begin n_fail++; $display("FAIL bp_ready[%0d] got %b exp %b", i, ireqready_o, i < 4); end
      if (ireqready_o) issued++;
      @(posedge clk); #1;
    end
    ireqvalid_i = 1'b0;
    n_checks++; if (issued != 4) begin n_fail++; $display("FAIL bp_accepted got %0d exp 4", issued); end
    n_checks++; if (dut.level_q !== 3'd4) begin n_fail++; $display("FAIL bp_level got %0d exp 4", dut.level_q); end
    irspready_i = 1'b1;
    @(negedge clk);
    n_checks++; if (ireqready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready_before_pop got %b exp 0", ireqready_o); end
    d0 = irspdata_o;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (ireqready_o !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_pop got %b exp 1", ireqready_o); end
    d1 = irspdata_o;
    @(posedge clk); #1;
    drain(2, 10);
    n_checks++; if (d0 !== 32'hC0DE0008) begin n_fail++; $display("FAIL bp_rsp0 got %h exp c0de0008", d0); end
    n_checks++; if (d1 !== 32'hC0DE0009) begin n_fail++; $display("FAIL bp_rsp1 got %h exp c0de0009", d1); end
    n_checks++; if (got_q.size() != 2) begin n_fail++; $display("FAIL bp_count got %0d exp 2", got_q.size()); end
    for (int i = 0; i < 2 && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== {1'b0, 32'hC0DE000A + 32'(i)}) begin n_fail++; $display("FAIL bp_rsp%0d got %h exp %h", i + 2, got_q[i], {1'b0, 32'hC0DE000A + 32'(i)}); end
    end
  endtask

  task automatic test_stream();
    int max_lvl = 0;
    irspready_i = 1'b1;
    got_q.delete();
    for (int c = 0; c < 14; c++) begin
      ireqvalid_i = (c < 8); ireqaddr_i = 32'h40 + 32'(4 * c);
      @(negedge clk);
      if (c < 8) begin
        n_checks++; if (ireqready_o !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d] got %b exp 1", c, ireqready_o); end
      end
      if (irspvalid_o) got_q.push_back({irsprerr_o, irspdata_o});
      if (int'(dut.level_q) > max_lvl) max_lvl = int'(dut.level_q);
      @(posedge clk); #1;
    end
    ireqvalid_i = 1'b0;
    n_checks++; if (got_q.size() != 8) begin n_fail++; $display("FAIL stream_count got %0d exp 8", got_q.size()); end
    n_checks++; if (max_lvl > 2) begin n_fail++; $display("FAIL stream_max_level got %0d exp <=2", max_lvl); end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== {1'b0, 32'hC0DE0010 + 32'(i)}) begin n_fail++; $display("FAIL stream_rsp%0d got %h exp %h", i, got_q[i], {1'b0, 32'hC0DE0010 + 32'(i)}); end
    end
  endtask

  task automatic test_clk_en();
    irspready_i = 1'b0; ireqvalid_i = 1'b1; ireqaddr_i = 32'h80;
    @(negedge clk);
    n_checks++; if (mem_addr_o !== 10'd32) begin n_fail++; $display("FAIL ce_mem_addr got %0d exp 32", mem_addr_o); end
    @(posedge clk); #1;
    ireqaddr_i = 32'h84;
    @(posedge clk); #1;
    clk_en_i = 1'b0; irspready_i = 1'b1; ireqaddr_i = 32'h88;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++; if (irspvalid_o !== 1'b1) begin n_fail++; $display("FAIL ce_stall_valid[%0d] got %b exp 1", k, irspvalid_o); end
      n_checks++; if (irspdata_o !== 32'hC0DE0020) begin n_fail++; $display("FAIL ce_stall_data[%0d] got %h exp c0de0020", k, irspdata_o); end
      n_checks++; if (mem_en_o !== 1'b0) begin n_fail++; $display("FAIL ce_stall_mem_en[%0d] got %b exp 0", k, mem_en_o); end
      n_checks++; if (ireqready_o !== 1'b0) begin n_fail++; $display("FAIL ce_stall_ready[%0d] got %b exp 0", k, ireqready_o); end
      n_checks++; if (dut.level_q !== 3'd2) begin n_fail++; $display("FAIL ce_stall_level[%0d] got %0d exp 2", k, dut.level_q); end
      @(posedge clk); #1;
    end
    clk_en_i = 1'b1; ireqvalid_i = 1'b0;
    @(negedge clk);
    n_checks++; if (irspdata_o !== 32'hC0DE0020) begin n_fail++; $display("FAIL ce_resume_a got %h exp c0de0020", irspdata_o); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (irspvalid_o !== 1'b1) begin n_fail++; $display("FAIL ce_resume_b_valid got %b exp 1", irspvalid_o); end
    n_checks++; if (irspdata_o !== 32'hC0DE0021) begin n_fail++; $display("FAIL ce_resume_b got %h exp c0de0021", irspdata_o); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (irspvalid_o !== 1'b0) begin n_fail++; $display("FAIL ce_resume_empty got %b exp 0", irspvalid_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    irspready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ireqvalid_i = 1'b1; ireqaddr_i = 32'h100 + 32'(4 * i);
      @(posedge clk); #1;
    end
    ireqvalid_i = 1'b0;
    #1;
    n_checks++; if (dut.level_q !== 3'd4) begin n_fail++; $display("FAIL ar_pre_level got %0d exp 4", dut.level_q); end
    #1 reset_i = 1'b1;
    #1;
    n_checks++; if (irspvalid_o !== 1'b0) begin n_fail++; $display("FAIL ar_valid got %b exp 0", irspvalid_o); end
    n_checks++; if (dut.level_q !== 3'd0) begin n_fail++; $display("FAIL ar_level got %0d exp 0", dut.level_q); end
    n_checks++; if (ireqready_o !== 1'b0) begin n_fail++; $display("FAIL ar_ready got %b exp 0", ireqready_o); end
    @(posedge clk); #1;
    reset_i = 1'b0;
    ireqvalid_i = 1'b1; ireqaddr_i = 32'h10;
    @(negedge clk);
    @(posedge clk); #1;
    ireqvalid_i = 1'b0;
    @(negedge clk);
    n_checks++; if (irspvalid_o !== 1'b0) begin n_fail++; $display("FAIL ar_stale_valid got %b exp 0", irspvalid_o); end
    @(posedge clk); #1;
    irspready_i = 1'b1;
    @(negedge clk);
    n_checks++; if (irspvalid_o !== 1'b1) begin n_fail++; $display("FAIL ar_fetch_valid got %b exp 1", irspvalid_o); end
    n_checks++; if (irspdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ar_fetch_data got %h exp deadbeef", irspdata_o); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (irspvalid_o !== 1'b0) begin n_fail++; $display("FAIL ar_only_one got %b exp 0", irspvalid_o); end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout, simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) sram[i] = 32'hC0DE0000 | 32'(i);
    sram[4] = 32'hDEADBEEF;
    mem_rdata_i = '0;
    test_reset();
    test_single();
    test_errors();
    test_backpressure();
    test_stream();
    test_clk_en();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_mem_bridge.md
Name: ifetch_mem_bridge

Overview:
- Sits directly upstream of the prefetch unit and serves its instruction request/response interface (ireq*/irsp*) from a single-port synchronous instruction SRAM.
- Accepts word fetch requests and range/alignment-checks them.
- Issues in-range reads to the SRAM and tracks in-flight reads through a fixed-latency pipeline.
- Buffers results in an in-order response FIFO that drains under the consumer's irspready handshake.

Parameters:
- C_BUS_SZX, 5: bus width base-2 exponent.
- C_BUS_SZ, 2**C_BUS_SZX: data/address width (derived).
- C_MEM_LAT, 1: SRAM read latency in enabled cycles; legal range 1..4.
- C_RSP_DEPTH_X, 2: response FIFO depth exponent; 2**C_RSP_DEPTH_X must be >= C_MEM_LAT+1.
- C_ADDR_BASE, 0: byte base address of the SRAM window; aligned to window size.
- C_ADDR_SIZE_X, 12: SRAM window size exponent in bytes (4 KiB default).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous active-high reset.
- clk_en_i  in  1  global clock enable; all state advances only when high.
- ireqready_o  out  1  request accepted this cycle if ireqvalid_i is high.
- ireqvalid_i  in  1  fetch request valid.
- ireqhpl_i  in  2  requester privilege level.
- ireqaddr_i  in  C_BUS_SZ  fetch byte address.
- irspready_i  in  1  consumer can take a response.
- irspvalid_o  out  1  response available.
- irsprerr_o  out  1  response is a fetch error.
- irspdata_o  out  C_BUS_SZ  instruction word.
- mem_ce_o  out  1  SRAM clock enable; equal to clk_en_i.
- mem_en_o  out  1  SRAM read strobe.
- mem_addr_o  out  C_ADDR_SIZE_X-2  SRAM word address.
- mem_rdata_i  in  C_BUS_SZ  SRAM read data, valid C_MEM_LAT enabled cycles after mem_en_o.

Behaviour:
- Reset:
  - level counter, latency pipeline and FIFO pointers cleared.
  - ireqready_o=0 while reset_i high; irspvalid_o=0, irsprerr_o=0, mem_en_o=0, mem_addr_o=0.
  - irspdata_o is don't-care when irspvalid_o=0.
  - Reset mid-operation discards all in-flight and buffered responses.
- Accept: accept = clk_en_i & ireqvalid_i & ireqready_o.
- ireqready_o = clk_en_i & (level_q != 2**C_RSP_DEPTH_X). It has no combinational dependence on irspready_i.
- level_q (width C_RSP_DEPTH_X+1) counts in-flight plus buffered responses:
  - +1 on accept only; -1 on pop only; unchanged on both or neither.
  - Never exceeds capacity and never underflows.
- Error classification on accept; err=1 if any of:
  - ireqaddr_i[1:0] != 0;
  - ireqaddr_i outside [C_ADDR_BASE, C_ADDR_BASE + 2**C_ADDR_SIZE_X);
  - ireqhpl_i == 2'b10 (reserved level).
- SRAM issue:
  - mem_en_o = accept & ~err.
  - mem_addr_o = ireqaddr_i[C_ADDR_SIZE_X-1:2], combinational from the request.
  - Erroring requests never touch the SRAM.
- Latency pipeline: C_MEM_LAT stages of {valid, err}, advancing only when clk_en_i is high.
  - On the stage-C_MEM_LAT output, push {err, err ? 0 : mem_rdata_i} into the FIFO.
  - The SRAM holds its output while mem_ce_o is low, so stalls are transparent.
- Response FIFO: synchronous, 2**C_RSP_DEPTH_X entries, no flush.
  - irspvalid_o = ~empty. Pop = clk_en_i & irspvalid_o & irspready_i.
  - No empty bypass: first irspvalid_o appears C_MEM_LAT+1 enabled cycles after accept.
- Ordering: responses are returned strictly in request order, errors included.
- Overflow: the FIFO cannot overflow by construction of level_q; push to a full FIFO is illegal and is asserted against.
- Simultaneous push and pop at any level, including full, is legal; the level is unchanged.
- Throughput: one request per cycle while credits remain. With the depth constraint met and irspready_i held high, sustained rate is 1/cycle.
- clk_en_i low: no accept, no pop, pipeline and counters frozen, mem_en_o=0.

Test Plan:
- Reset then single fetch at 0x0000_0010 with SRAM word 4 = 0xDEADBEEF (C_MEM_LAT=1) -> mem_en_o=1 and mem_addr_o=4 in accept cycle; irspvalid_o=1, irsprerr_o=0, data 0xDEADBEEF two cycles later.
- Fetches at 0x0000_1000 (out of range), 0x0000_0002 (misaligned), and with ireqhpl_i=2'b10 -> mem_en_o stays 0; each response has irsprerr_o=1, data 0; order preserved.
- irspready_i=0, issue back-to-back requests -> exactly 4 accepted, then ireqready_o=0. Raise irspready_i -> 4 responses in order, and ireqready_o returns the cycle after the first pop.
- Streaming 8 sequential fetches with irspready_i=1 -> one accept per cycle, 8 in-order responses, level_q never exceeds 2.
- clk_en_i low for 3 cycles with 2 reads in flight -> no outputs change. After re-enable, responses arrive with correct data and the pipeline delay is unchanged in enabled cycles.
- Assert reset_i asynchronously with 3 entries buffered and 1 in flight -> irspvalid_o=0 immediately, level_q=0, and the first post-reset fetch returns correct data.
